// File: rtl/turbo_pkg.sv
// Shared constants and types for the RSC encoder and the decoder trellis.
// Generator bit MEMORY weights the feedback node; bits MEMORY-1..0 tap r1..r3.
package turbo_pkg;
   localparam int MEMORY = 3;
   localparam logic [MEMORY:0] G_FB = 4'b1011;
   localparam logic [MEMORY:0] G_FF = 4'b1101;

   typedef logic [MEMORY-1:0] rsc_state_t;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_TAIL,
      ST_DONE
   } enc_fsm_t;
endpackage

// File: rtl/rsc_step.sv
// One combinational trellis step of the 13/15 octal RSC code.
// state = {r1, r2, r3}, so the state index is r1*4 + r2*2 + r3.
module rsc_step
   import turbo_pkg::*;
(
   input  rsc_state_t state,
   input  logic       u,
   input  logic       tail,
   output logic       sys,
   output logic       parity,
   output rsc_state_t next_state
);

   logic fb;
   logic a;

   always_comb begin
      fb         = ^(G_FB[MEMORY-1:0] & state);
      // During termination the input cancels the feedback, driving a to 0.
      sys        = tail ? fb : u;
      a          = sys ^ fb;
      parity     = (G_FF[MEMORY] & a) ^ (^(G_FF[MEMORY-1:0] & state));
      next_state = {a, state[MEMORY-1:1]};
   end

endmodule

// File: rtl/rsc_frame_encoder.sv
// Frame encoder: K data steps, MEMORY tail steps, then the full code frame
// is presented with a valid/ready handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// LOAD    | accept data bits while in_ready = 1, one step per accepted bit
// TAIL    | MEMORY termination steps, no input consumed
// DONE    | frame held; out_valid rises one cycle after entry, ends on out_ready
module rsc_frame_encoder
   import turbo_pkg::*;
#(
   parameter int SYMBOLS         = 10,
   parameter int BITS_PER_SYMBOL = 2
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     in_valid,
   input  logic                                     in_bit,
   output logic                                     in_ready,
   input  logic                                     out_ready,
   output logic                                     out_valid,
   output logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0]  code,
   output rsc_state_t                               final_state
);

   localparam int K     = SYMBOLS - MEMORY;
   localparam int CNT_W = $clog2(SYMBOLS);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(K - 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SYMBOLS - 1);

   enc_fsm_t         fsm;
   rsc_state_t       r;
   logic [CNT_W-1:0] cnt;

   logic       step_sys;
   logic       step_parity;
   rsc_state_t step_next;

   rsc_step u_step (
      .state      (r),
      .u          (in_bit),
      .tail       (fsm == ST_TAIL),
      .sys        (step_sys),
      .parity     (step_parity),
      .next_state (step_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm         <= ST_LOAD;
         r           <= '0;
         cnt         <= '0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         code        <= '0;
         final_state <= '0;
      end else begin
         case (fsm)
            ST_LOAD: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  code[0][cnt] <= step_sys;
                  code[1][cnt] <= step_parity;
                  r            <= step_next;
                  cnt          <= cnt + 1'b1;
                  if (cnt == LAST_DATA) begin
                     fsm      <= ST_TAIL;
                     in_ready <= 1'b0;
                  end
               end
            end

            ST_TAIL: begin
               code[0][cnt] <= step_sys;
               code[1][cnt] <= step_parity;
               r            <= step_next;
               cnt          <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  fsm         <= ST_DONE;
                  final_state <= step_next;
               end
            end

            ST_DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r         <= '0;
                  cnt       <= '0;
                  fsm       <= ST_LOAD;
               end
            end

            default: fsm <= ST_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_rsc_frame_encoder.sv
// Scoreboard bench for rsc_frame_encoder with default parameters (K = 7).
module tb_rsc_frame_encoder;

   typedef logic [1:0][9:0] frame_t;
   typedef struct {
      frame_t     code;
      logic [2:0] fs;
      int         t_last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_bit;
   logic       in_ready;
   logic       out_ready = 1'b0;
   logic       out_valid;
   frame_t     code;
   logic [2:0] final_state;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   bp_pct = 0;
   exp_t q[$];

   // Hand-computed frames; bit k of each row is trellis step k.
   localparam frame_t F_IMPULSE = {10'b0011001111, 10'b0010000001};
   localparam frame_t F_ONES    = {10'b0001000101, 10'b0001111111};

   rsc_frame_encoder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .in_ready    (in_ready),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .code        (code),
      .final_state (final_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, got, want);
      end
   endtask

   function automatic frame_t model(input logic [6:0] d);
      frame_t f;
      logic r1, r2, r3, u, a, p;
      r1 = 0; r2 = 0; r3 = 0;
      f  = '0;
      for (int k = 0; k < 10; k++) begin
         u = (k < 7) ? d[k] : (r2 ^ r3);
         a = u ^ r2 ^ r3;
         p = a ^ r1 ^ r3;
         f[0][k] = u;
         f[1][k] = p;
         r3 = r2; r2 = r1; r1 = a;
      end
      return f;
   endfunction

   // Sends the first nbits of d; a full frame (nbits = 7) pushes its expectation.
   task automatic send_frame(input logic [6:0] d, input frame_t exp_code, input int nbits,
                             input int gap_pct, input bit hold);
      int   i = 0;
      int   guard = 0;
      exp_t e;
      while (i < nbits) begin
         @(negedge clk);
         guard++;
         if (guard > 1000) begin
            chk("send_timeout", 32'(i), 32'(nbits));
            return;
         end
         if (!in_ready) begin
            in_valid = hold;
            in_bit   = 1'($urandom_range(1));
         end else if ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            in_bit   = 1'($urandom_range(1));
         end else begin
            in_valid = 1'b1;
            in_bit   = d[i];
            i++;
            if (i == 7) begin
               e.code   = exp_code;
               e.fs     = 3'd0;
               e.t_last = cyc + 1;
               q.push_back(e);
            end
         end
      end
      if (hold) begin
         @(negedge clk);
         in_bit = 1'($urandom_range(1));
      end
   endtask

   task automatic drain();
      for (int g = 0; g < 500 && (q.size() != 0 || !in_ready); g++) @(negedge clk);
      chk("drain", 32'(q.size() == 0 && in_ready), 32'd1);
   endtask

   task automatic chk_reset_values();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_code", 32'(code), 32'd0);
      chk("rst_final_state", 32'(final_state), 32'd0);
   endtask

   // Monitor: owns out_ready, pops the scoreboard on each new frame.
   bit     prev_valid = 0;
   bit     hs_pending = 0;
   frame_t held;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_valid = 0;
         hs_pending = 0;
         out_ready  = 1'b0;
      end else begin
         chk("ready_valid_exclusive", 32'(in_ready && out_valid), 32'd0);
         if (hs_pending) begin
            chk("release_valid", 32'(out_valid), 32'd0);
            chk("release_ready", 32'(in_ready), 32'd1);
            hs_pending = 0;
         end
         if (out_valid && !prev_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_frame", 32'(out_valid), 32'd0);
            end else begin
               e = q.pop_front();
               chk("code_sys", 32'(code[0]), 32'(e.code[0]));
               chk("code_par", 32'(code[1]), 32'(e.code[1]));
               chk("final_state", 32'(final_state), 32'(e.fs));
               chk("latency", 32'(cyc), 32'(e.t_last + 4));
            end
            held = code;
         end else if (out_valid) begin
            chk("hold_code", 32'(code), 32'(held));
         end
         if (q.size() > 0 && cyc >= q[0].t_last && !out_valid)
            chk("tail_in_ready", 32'(in_ready), 32'd0);
         prev_valid = out_valid;
         out_ready  = ($urandom_range(99) >= bp_pct);
         if (out_valid && out_ready) hs_pending = 1;
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [6:0] d;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_values();
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 32'(in_ready), 32'd1);

      // Directed frames, out_ready always high (single-cycle presentation).
      bp_pct = 0;
      send_frame(7'b0000001, F_IMPULSE, 7, 0, 0);
      send_frame(7'b0000000, '0, 7, 0, 0);
      send_frame(7'b1111111, F_ONES, 7, 0, 1);
      bp_pct = 60;
      send_frame(7'b0000001, F_IMPULSE, 7, 30, 1);
      send_frame(7'b1111111, F_ONES, 7, 20, 1);
      drain();

      // Partial frame then reset: nothing may be presented for it.
      bp_pct = 0;
      send_frame(7'b1011010, '0, 4, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      chk_reset_values();
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_midreset", 32'(in_ready), 32'd1);
      send_frame(7'b1111111, F_ONES, 7, 0, 0);
      send_frame(7'b0000001, F_IMPULSE, 7, 0, 1);

      for (int n = 0; n < 60; n++) begin
         d      = 7'($urandom);
         bp_pct = $urandom_range(0, 70);
         send_frame(d, model(d), 7, $urandom_range(0, 40), 1'($urandom_range(1)));
      end
      drain();
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
